// File: rtl/dram_wr_arbiter.sv
// rtl/dram_wr_arbiter.sv - two-source DRAM-cache write arbiter with a registered output slot
//
// Purpose:
//   Merges read-miss fill writes and host writes into a single DRAM-cache
//   write port. The winning request is captured into a one-deep output
//   register that can be refilled in the same cycle it drains, which gives
//   one transfer per clock when the write port keeps ready_i high.
//   By default fill requests win over host requests so that miss data can
//   unblock pending reads as early as possible.
//
// Optional feature:
//   DRAM_WR_ARB_STARVE_EN - when defined, a 4-bit saturating counter tracks
//   consecutive fill grants taken while a host request waits. Once it
//   reaches STARVE_LIMIT and both sides are valid, the host wins one grant.
//   When undefined, fill always wins and host traffic may starve.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   fill_valid_i  in   fill request valid
//   fill_ready_o  out  fill request accepted this cycle (combinational)
//   fill_wdata_i  in   fill {addr, data}
//   host_valid_i  in   host write request valid
//   host_ready_o  out  host request accepted this cycle (combinational)
//   host_wdata_i  in   host {addr, data}
//   valid_o       out  output slot holds a write request
//   ready_i       in   DRAM-cache write port accepts
//   wdata_o       out  registered winning {addr, data}
//   src_o         out  source of wdata_o: 0 = fill, 1 = host

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 512
`endif

module dram_wr_arbiter #(
  parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
  parameter int WDATA_WIDTH  = ADDR_WIDTH + DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   fill_valid_i,
  output logic                   fill_ready_o,
  input  logic [WDATA_WIDTH-1:0] fill_wdata_i,

  input  logic                   host_valid_i,
  output logic                   host_ready_o,
  input  logic [WDATA_WIDTH-1:0] host_wdata_i,

  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WDATA_WIDTH-1:0] wdata_o,
  output logic                   src_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  // Limit truncated to the counter width; legal range is 1..15.
  localparam logic [3:0] LP_STARVE_LIMIT = STARVE_LIMIT[3:0];

  logic [0:0]             r_state;
  logic [WDATA_WIDTH-1:0] r_wdata;
  logic                   r_src;

  logic                   w_slot_free;
  logic                   w_host_pri;
  logic                   w_fill_gnt;
  logic                   w_host_gnt;
  logic                   w_any_gnt;

  // ---------------------------------------------------------------------------
  // Optional starvation guard
  // ---------------------------------------------------------------------------
`ifdef DRAM_WR_ARB_STARVE_EN
  logic [3:0] r_starve_cnt;

  // Host takes priority only once fill has won STARVE_LIMIT times in a row
  // while the host was waiting.
  assign w_host_pri = (r_starve_cnt == LP_STARVE_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (!host_valid_i || w_host_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (w_fill_gnt && (r_starve_cnt != 4'hF)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  logic w_unused_starve_limit;

  assign w_host_pri            = 1'b0;
  assign w_unused_starve_limit = ^LP_STARVE_LIMIT;
`endif

  // ---------------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------------
  // The slot can take a new request when it is empty, or when its current
  // content leaves this cycle. Reset forces both readies low so nothing is
  // accepted while the block is being cleared.
  always_comb begin
    w_slot_free = 1'b0;
    w_fill_gnt  = 1'b0;
    w_host_gnt  = 1'b0;

    w_slot_free = !rst && ((r_state == S_IDLE) || ready_i);
    w_fill_gnt  = w_slot_free && fill_valid_i && !(w_host_pri && host_valid_i);
    w_host_gnt  = w_slot_free && host_valid_i && (!fill_valid_i || w_host_pri);
  end

  assign w_any_gnt    = w_fill_gnt || w_host_gnt;
  assign fill_ready_o = w_fill_gnt;
  assign host_ready_o = w_host_gnt;

  // ---------------------------------------------------------------------------
  // Output slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wdata <= '0;
      r_src   <= 1'b0;
    end else if (w_any_gnt) begin
      // Load the winner; this also covers drain-and-refill in one cycle.
      r_state <= S_HOLD;
      r_wdata <= w_host_gnt ? host_wdata_i : fill_wdata_i;
      r_src   <= w_host_gnt;
    end else if ((r_state == S_HOLD) && ready_i) begin
      // Drained with nothing to replace it; data is left in place, only
      // valid drops.
      r_state <= S_IDLE;
    end
  end

  // valid is masked during reset so a held request is never offered while
  // it is being discarded.
  assign valid_o = (r_state == S_HOLD) && !rst;
  assign wdata_o = r_wdata;
  assign src_o   = r_src;

endmodule

// File: doc/dram_wr_arbiter.md
DRAM_WR_ARBITER -- requirements
Module: dram_wr_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDR_WIDTH, `AXI_ADDR_WIDTH, cache line address width.
- DATA_WIDTH, `AXI_DATA_WIDTH, line data width.
- WDATA_WIDTH, ADDR_WIDTH+DATA_WIDTH, packed request width: {addr, data}, with data in the low bits.
- STARVE_LIMIT, 4, consecutive fill grants allowed while a host request waits (range 1..15).

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, reset; synchronous, active-high.
- fill_valid_i, input, 1, read-miss fill request valid.
- fill_ready_o, output, 1, fill request accepted this cycle.
- fill_wdata_i, input, WDATA_WIDTH, fill {addr, data}.
- host_valid_i, input, 1, host write request valid.
- host_ready_o, output, 1, host request accepted this cycle.
- host_wdata_i, input, WDATA_WIDTH, host {addr, data}.
- valid_o, output, 1, DRAM-cache write request valid.
- ready_i, input, 1, DRAM-cache write port accepts.
- wdata_o, output, WDATA_WIDTH, registered winning {addr, data}.
- src_o, output, 1, source of wdata_o: 0 = fill, 1 = host.

Function
REQ-003 The block SHALL implement a two-state FSM: S_IDLE (output register empty) and S_HOLD (output register full).
REQ-004 valid_o SHALL equal (state == S_HOLD); wdata_o and src_o SHALL come directly from registers.
REQ-005 The block SHALL accept a request in a cycle only if (state == S_IDLE) or (ready_i == 1); this condition is "slot_free".
REQ-006 When slot_free is true and at least one request is valid, the block SHALL grant exactly one requester.
- fill_ready_o and host_ready_o are combinational.
- fill_ready_o and host_ready_o are never both 1.
- Neither ready is asserted toward a requester whose valid is low.
REQ-007 Default priority SHALL be fill over host, so that miss data unblocks pending reads.
REQ-008 On a grant, the block SHALL load the winner's wdata into wdata_o and its source into src_o at the next edge, and the state SHALL become S_HOLD.
- Latency from request to output is 1 cycle.
REQ-009 In S_HOLD with ready_i=1 and no grant, the state SHALL go to S_IDLE; with ready_i=1 and a grant, it SHALL stay in S_HOLD with the new data, giving one transfer per cycle.
REQ-010 In S_HOLD with ready_i=0, wdata_o and src_o SHALL hold stable, and both ready outputs SHALL be 0.
REQ-011 Requesters SHALL hold valid and wdata stable until their ready is seen; the block does not buffer unaccepted requests.
REQ-012 No request SHALL be duplicated or dropped.
- Every accepted request appears on valid_o exactly once.
- Requests from the same source appear in acceptance order.

Reset
REQ-013 While rst=1 at a clock edge, the block SHALL set state to S_IDLE, wdata_o to 0, src_o to 0 and starve_cnt to 0.
REQ-014 During reset cycles, valid_o, fill_ready_o and host_ready_o SHALL be 0 regardless of inputs.
REQ-015 A reset asserted while in S_HOLD SHALL discard the held request; valid_o SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-016 The macro DRAM_WR_ARB_STARVE_EN SHALL compile the starvation guard in or out.
REQ-017 With DRAM_WR_ARB_STARVE_EN defined, the block SHALL keep a 4-bit saturating starve_cnt.
- Increment on each fill grant while host_valid_i=1.
- Clear on a host grant, or in any cycle with host_valid_i=0.
- When starve_cnt == STARVE_LIMIT and both requesters are valid, the host SHALL win.
REQ-018 Without DRAM_WR_ARB_STARVE_EN, starve_cnt SHALL not exist and fill SHALL always win.
- Host requests can starve indefinitely under continuous fill traffic; this is intended.

Verification
REQ-019 The bench SHALL cover these directed scenarios.
- Reset then idle -> valid_o=0, both ready outputs=0, wdata_o=0, src_o=0.
- Single fill {addr=0x40, data=0xAA} with ready_i=1 -> fill_ready_o=1 in cycle 0; valid_o=1, src_o=0, wdata_o={0x40,0xAA} in cycle 1; valid_o=0 in cycle 2.
- Fill and host valid together, ready_i=1, macro off -> fill granted first; host granted the next cycle; src_o sequence 0,1 with no bubble.
- Both requesters continuously valid, ready_i=1, macro on, STARVE_LIMIT=4 -> src_o pattern 0,0,0,0,1 repeating.
- ready_i held at 0 for 5 cycles with one held host request -> wdata_o stable, both ready outputs 0; single transfer when ready_i=1.
- rst=1 asserted in S_HOLD with held data 0x55 -> valid_o=0 next cycle; later traffic unaffected.
